// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO registers.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;
  state_t state, state_next;
  logic [1:0] op_r;
  logic sa, sb, bz;
  logic [WIDTH-1:0] a_r, b_r, ma, mb, q;
  logic [2*WIDTH-1:0] acc, prod;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0] add_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub, quo, rem, res_hi, res_lo;
  logic is_div, ge, accept;
  assign is_div = op_r[1];
  assign busy = state != IDLE;
  assign accept = start && !abort;
  // The low half of acc collects product bits in multiply; the high half is the partial sum or remainder.
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, q[0] ? ma : '0};
  assign rem_sh = {acc[2*WIDTH-1:WIDTH], q[WIDTH-1]};
  assign ge = rem_sh >= {1'b0, mb};
  assign rem_sub = rem_sh[WIDTH-1:0] - mb;
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo = (sa ^ sb) ? -q : q;
  assign rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res_hi = is_div ? (bz ? a_r : rem) : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (bz ? '1 : quo) : prod[WIDTH-1:0];
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = accept ? PREP : IDLE;
      PREP: state_next = ITER;
      ITER: state_next = (cnt == '0) ? FIX : ITER;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      op_r <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      ma <= '0;
      mb <= '0;
      q <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      done <= state == FIX && !abort;
      div_by_zero <= state == FIX && !abort && is_div && bz;
      case (state)
        IDLE: begin
          if (accept) begin
            op_r <= op;
            sa <= ~op[0] & a[WIDTH-1];
            sb <= ~op[0] & b[WIDTH-1];
            a_r <= a;
            b_r <= b;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        PREP: begin
          ma <= sa ? -a_r : a_r;
          mb <= sb ? -b_r : b_r;
          q <= is_div ? (sa ? -a_r : a_r) : (sb ? -b_r : b_r);
          bz <= b_r == '0;
          acc <= '0;
          cnt <= CNT_W'(WIDTH - 1);
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc[2*WIDTH-1:WIDTH] <= ge ? rem_sub : rem_sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ge};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
            q <= q >> 1;
          end
        end
        FIX: begin
          if (!abort) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: scoreboard bench for mips_muldiv at WIDTH=32 and WIDTH=16.
module tb_mips_muldiv;
  typedef struct {
    logic [63:0] h;
    logic [63:0] l;
    logic        z;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic s_start = 1'b0;
  logic [1:0] s_op = '0;
  logic [15:0] s_a = '0, s_b = '0;
  logic s_busy, s_done, s_dbz;
  logic [15:0] s_hi, s_lo;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q32[$], q16[$];
  exp_t e32, e16;

  mips_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  mips_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b), .abort(1'b0),
    .mthi(1'b0), .mtlo(1'b0), .wdata(16'h0), .busy(s_busy), .done(s_done),
    .div_by_zero(s_dbz), .hi(s_hi), .lo(s_lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int n, input logic [1:0] o, input logic [63:0] x,
                                 input logic [63:0] y, input int due);
    exp_t e;
    logic [63:0] m, ux, uy, pr;
    longint sx, sy;
    m = (64'd1 << n) - 64'd1;
    ux = x & m;
    uy = y & m;
    sx = longint'(ux << (64 - n));
    sx = sx >>> (64 - n);
    sy = longint'(uy << (64 - n));
    sy = sy >>> (64 - n);
    e.z = 1'b0;
    e.due = due;
    if (!o[1]) begin
      pr = o[0] ? ux * uy : 64'(sx * sy);
      e.h = (pr >> n) & m;
      e.l = pr & m;
    end else if (uy == 0) begin
      e.h = ux;
      e.l = m;
      e.z = 1'b1;
    end else if (o[0]) begin
      e.l = ux / uy;
      e.h = ux % uy;
    end else begin
      e.l = 64'(sx / sy) & m;
      e.h = 64'(sx % sy) & m;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (q32.size() == 0) chk("extra_done", 1, 0);
        else begin
          e32 = q32.pop_front();
          chk("hi", hi, e32.h);
          chk("lo", lo, e32.l);
          chk("dbz", div_by_zero, e32.z);
          chk("latency", cyc, e32.due);
        end
      end else if (q32.size() > 0 && cyc > q32[0].due) begin
        chk("no_done", 0, 1);
        void'(q32.pop_front());
      end
      if (div_by_zero && !done) chk("dbz_without_done", 1, 0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (s_done) begin
        if (q16.size() == 0) chk("w16_extra_done", 1, 0);
        else begin
          e16 = q16.pop_front();
          chk("w16_hi", s_hi, e16.h);
          chk("w16_lo", s_lo, e16.l);
          chk("w16_dbz", s_dbz, e16.z);
          chk("w16_latency", cyc, e16.due);
        end
      end else if (q16.size() > 0 && cyc > q16[0].due) begin
        chk("w16_no_done", 0, 1);
        void'(q16.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    q32.push_back(model(32, o, {32'h0, x}, {32'h0, y}, cyc + 35));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    s_op = o;
    s_a = x;
    s_b = y;
    s_start = 1'b1;
    q16.push_back(model(16, o, {48'h0, x}, {48'h0, y}, cyc + 19));
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || s_busy || q32.size() != 0 || q16.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 34);
    wait_idle();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'b11, 32'd7, 32'd0);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF0, 32'd0);
    wait_idle();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_idle();
    wdata = 32'h1234;
    mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b1;
    wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    op = 2'b00;
    a = 32'd3;
    b = 32'd4;
    start = 1'b1;
    mthi = 1'b1;
    wdata = 32'hDEAD;
    @(negedge clk);
    mthi = 1'b0;
    chk("start_busy", busy, 1);
    chk("mthi_with_start", hi, 32'h1234);
    repeat (4) @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hBEEF;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("abort_hi", hi, 32'h1234);
    chk("abort_lo", lo, 32'h5678);
    start = 1'b1;
    abort = 1'b1;
    mthi = 1'b1;
    wdata = 32'hABC;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    mthi = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_mthi", hi, 32'hABC);
    repeat (40) @(negedge clk);
    op = 2'b10;
    a = 32'd100;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    repeat (40) @(negedge clk);
    issue(2'b11, 32'd100, 32'd7);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      issue(2'(i), $urandom, (i == 5) ? 32'd0 : $urandom);
      wait_idle();
    end
    issue16(2'b00, 16'hFFFD, 16'd5);
    wait_idle();
    issue16(2'b01, 16'hFFFF, 16'hFFFF);
    wait_idle();
    issue16(2'b10, 16'h8000, 16'hFFFF);
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
